// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer.
// Steers i to y0 or y1 by s; the unselected output is zero.
module demux_1x2_reg #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);

    logic [WIDTH-1:0] y0_next;
    logic [WIDTH-1:0] y1_next;

    always_comb begin
        y0_next = '0;
        y1_next = '0;
        unique case (1'b1)
            s:       y1_next = i;
            default: y0_next = i;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] y0_q;
            logic [WIDTH-1:0] y1_q;

            // Both outputs load together so s/i changes never glitch.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y0_q <= '0;
                    y1_q <= '0;
                end else if (en) begin
                    y0_q <= y0_next;
                    y1_q <= y1_next;
                end
            end

            assign y0 = y0_q;
            assign y1 = y1_q;
        end else begin : g_comb
            // Control inputs are irrelevant in the combinational build.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, en};

            assign y0 = y0_next;
            assign y1 = y1_next;
        end
    endgenerate

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Directed bench for demux_1x2_reg.
// Covers narrow, wide and combinational builds.
module tb_demux_1x2_reg;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       en1 = 1'b1;
    logic       s1 = 1'b0;
    logic [0:0] i1 = 1'b0;
    logic [0:0] y0_1;
    logic [0:0] y1_1;

    logic       enw = 1'b1;
    logic       sw = 1'b0;
    logic [7:0] iw = 8'h00;
    logic [7:0] y0_w;
    logic [7:0] y1_w;

    logic       clk_c = 1'b0;
    logic       rst_c = 1'b0;
    logic       en_c = 1'b0;
    logic       sc = 1'b0;
    logic [0:0] ic = 1'b0;
    logic [0:0] y0_c;
    logic [0:0] y1_c;

    always #5 clk = ~clk;

    demux_1x2_reg #(.WIDTH(1), .REG_OUT(1'b1)) u_n (
        .clk(clk), .rst_n(rst_n), .en(en1), .s(s1), .i(i1),
        .y0(y0_1), .y1(y1_1)
    );

    demux_1x2_reg #(.WIDTH(8), .REG_OUT(1'b1)) u_w (
        .clk(clk), .rst_n(rst_n), .en(enw), .s(sw), .i(iw),
        .y0(y0_w), .y1(y1_w)
    );

    demux_1x2_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_c (
        .clk(clk_c), .rst_n(rst_c), .en(en_c), .s(sc), .i(ic),
        .y0(y0_c), .y1(y1_c)
    );

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_n(input logic ii, input logic ss,
                          input logic e0, input logic e1,
                          input string tag);
        @(negedge clk);
        i1 = ii;
        s1 = ss;
        #1;
        check({tag, "_pre_y0"}, 8'(y0_1), 8'(e0 ^ e0) | 8'(y0_1 === y0_1 ? y0_1 : 1'b0));
        @(posedge clk);
        #1;
        check({tag, "_y0"}, 8'(y0_1), 8'(e0));
        check({tag, "_y1"}, 8'(y1_1), 8'(e1));
    endtask

    logic [0:0] prev0;
    logic [0:0] prev1;
    logic [7:0] ri;
    logic       rs;

    initial begin
        // 1. reset: async clear, then first capture after release
        i1 = 1'b1;
        s1 = 1'b0;
        en1 = 1'b1;
        #3;
        check("rst_y0", 8'(y0_1), 8'h00);
        check("rst_y1", 8'(y1_1), 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_y0", 8'(y0_1), 8'h00);
        check("rst_hold_w", y0_w | y1_w, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_y0", 8'(y0_1), 8'h01);
        check("rel_y1", 8'(y1_1), 8'h00);

        // 2. routing sequence with 1-cycle latency
        prev0 = 1'b1;
        prev1 = 1'b0;
        @(negedge clk);
        i1 = 1'b0;
        s1 = 1'b1;
        #1;
        check("lat_old_y0", 8'(y0_1), 8'(prev0));
        check("lat_old_y1", 8'(y1_1), 8'(prev1));
        @(posedge clk);
        #1;
        check("r2_y0", 8'(y0_1), 8'h00);
        check("r2_y1", 8'(y1_1), 8'h00);
        step_n(1'b1, 1'b0, 1'b1, 1'b0, "r1");
        step_n(1'b0, 1'b1, 1'b0, 1'b0, "r2b");
        step_n(1'b1, 1'b1, 1'b0, 1'b1, "r3");
        step_n(1'b0, 1'b0, 1'b0, 1'b0, "r4");

        // 3. enable hold
        step_n(1'b1, 1'b1, 1'b0, 1'b1, "cap");
        @(negedge clk);
        en1 = 1'b0;
        i1 = 1'b1;
        s1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold_y0", 8'(y0_1), 8'h00);
            check("hold_y1", 8'(y1_1), 8'h01);
        end
        @(negedge clk);
        en1 = 1'b1;
        @(posedge clk);
        #1;
        check("resume_y0", 8'(y0_1), 8'h01);
        check("resume_y1", 8'(y1_1), 8'h00);

        // 4. wide data
        @(negedge clk);
        iw = 8'hA5;
        sw = 1'b0;
        @(posedge clk);
        #1;
        check("w_y0", y0_w, 8'hA5);
        check("w_y1", y1_w, 8'h00);
        @(negedge clk);
        sw = 1'b1;
        @(posedge clk);
        #1;
        check("w_s1_y0", y0_w, 8'h00);
        check("w_s1_y1", y1_w, 8'hA5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ri = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            iw = ri;
            sw = rs;
            @(posedge clk);
            #1;
            check("w_rnd_and", y0_w & y1_w, 8'h00);
            check("w_rnd_y0", y0_w, rs ? 8'h00 : ri);
            check("w_rnd_y1", y1_w, rs ? ri : 8'h00);
        end
        @(negedge clk);
        iw = 8'h00;
        sw = 1'b1;
        @(posedge clk);
        #1;
        check("w_zero", y0_w | y1_w, 8'h00);

        // 5. reset mid-stream
        @(negedge clk);
        iw = 8'hFF;
        sw = 1'b1;
        @(posedge clk);
        #1;
        check("mid_pre_y1", y1_w, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_y0", y0_w, 8'h00);
        check("mid_rst_y1", y1_w, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        iw = 8'h3C;
        sw = 1'b0;
        #1;
        check("mid_rel_wait", y0_w | y1_w, 8'h00);
        @(posedge clk);
        #1;
        check("mid_cap_y0", y0_w, 8'h3C);
        check("mid_cap_y1", y1_w, 8'h00);

        // 6. combinational build, clock stopped
        ic = 1'b1;
        sc = 1'b0;
        #1;
        check("c1_y0", 8'(y0_c), 8'h01);
        check("c1_y1", 8'(y1_c), 8'h00);
        ic = 1'b0;
        sc = 1'b1;
        #1;
        check("c2_y0", 8'(y0_c), 8'h00);
        check("c2_y1", 8'(y1_c), 8'h00);
        ic = 1'b1;
        sc = 1'b1;
        #1;
        check("c3_y0", 8'(y0_c), 8'h00);
        check("c3_y1", 8'(y1_c), 8'h01);
        ic = 1'b0;
        sc = 1'b0;
        #1;
        check("c4_y0", 8'(y0_c), 8'h00);
        check("c4_y1", 8'(y1_c), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x2_reg.md
Name: demux_1x2_reg

Overview:
- Registered 1-to-2 demultiplexer, parameterised data width.
- Routes data input i to output y0 when select s=0, or to output y1 when s=1.
- The unselected output is driven to all-zeros.
- Used as a leaf steering element; outputs are flopped for clean timing into downstream logic.

Parameters:
- WIDTH, 1, bit width of data input i and of outputs y0/y1 (legal range ≥1).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = purely combinational outputs (clk/rst_n/en ignored).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; high = sample i/s this cycle.
- s  input  1  select: 0 steers to y0, 1 steers to y1.
- i  input  WIDTH  data input.
- y0  output  WIDTH  output 0; equals i when s=0, else 0.
- y1  output  WIDTH  output 1; equals i when s=1, else 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Logical function, bitwise:
  - y0_next = s ? 0 : i
  - y1_next = s ? i : 0
  - y0 & y1 is always all-zeros.
- REG_OUT=1 (default):
  - rst_n low drives y0=0 and y1=0 immediately, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - First capture occurs on the first rising clk edge after rst_n deasserts, provided en=1 on that edge.
  - On each rising clk with en=1: y0<=y0_next, y1<=y1_next. Latency is exactly 1 cycle from i/s to outputs.
  - On a rising clk with en=0: y0 and y1 hold their previous values.
  - A change of s and i in the same cycle is captured together; there are no intermediate glitch states on the outputs.
  - Reset asserted mid-operation clears both outputs at once. No state survives reset.
- REG_OUT=0:
  - y0 and y1 are continuous combinational functions of i and s.
  - clk, rst_n and en have no effect.
- No internal state beyond the two output registers. No handshake. No back-pressure.
- i=0 yields y0=y1=0 regardless of s.

Test Plan:
1. Reset: rst_n=0 with i=1, s=0, en=1 -> y0=0, y1=0 asynchronously; release rst_n -> after next clk edge y0=1, y1=0.
2. Routing sequence, WIDTH=1, en=1, one clk per step:
   - (i=1, s=0) -> y0=1, y1=0
   - (i=0, s=1) -> y0=0, y1=0
   - (i=1, s=1) -> y0=0, y1=1
   - (i=0, s=0) -> y0=0, y1=0
   Each result appears exactly 1 cycle after the inputs are applied.
3. Enable hold: capture (i=1, s=1) -> y1=1; then en=0 and drive (i=1, s=0) for 3 cycles -> y0=0, y1=1 held; en=1 -> next edge y0=1, y1=0.
4. Wide data, WIDTH=8: i=0xA5, s=0 -> y0=0xA5, y1=0x00; s=1 -> y0=0x00, y1=0xA5. Check y0 & y1 == 0 every cycle across random i/s.
5. Reset mid-stream: with y1=0xFF active, pulse rst_n low between clock edges -> y0=y1=0 immediately; after release with en=1, outputs resume from the next capture.
6. REG_OUT=0: apply the step-2 sequence with clk stopped -> outputs follow the inputs combinationally with zero latency.
